// File: rtl/farrow_interp_pp_pkg.sv
// Shared fixed-point constants and helpers for the symbol-timing recovery datapath.
// Holds the Q-format limits, the NCO reset mu and the output saturation function.
package timing_pkg;

    localparam int DATA_W   = 16;
    localparam int MU_WIDTH = 10;
    localparam int MU_FRAC  = 9;
    localparam int ACC_W    = 20;

    localparam int SAT_MAX  = 32767;
    localparam int SAT_MIN  = -32768;

    localparam int MU_RESET = 154;

    localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = ACC_W'(SAT_MIN);

    // Clamp a wide accumulator to the Q1.15 output range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > ACC_SAT_MAX) begin
            r = DATA_W'(SAT_MAX);
        end else if (v < ACC_SAT_MIN) begin
            r = DATA_W'(SAT_MIN);
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/farrow_mac_stage.sv
// One Farrow Horner step: registers (a * mu >>> MU_FRAC) + b, with the slot valid
// and an opaque side-band word travelling alongside the data.
module farrow_mac_stage
    import timing_pkg::*;
#(
    parameter int SIDE_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] a,
    input  logic [MU_WIDTH-1:0]     mu,
    input  logic signed [ACC_W-1:0] b,
    input  logic [SIDE_W-1:0]       side_in,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] sum,
    output logic [SIDE_W-1:0]       side_out
);

    localparam int PROD_W = ACC_W + MU_WIDTH + 1;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] mu_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  sum_next;

    // mu is unsigned, so it is zero-extended before the signed multiply.
    assign a_ext    = {{(MU_WIDTH + 1){a[ACC_W-1]}}, a};
    assign mu_ext   = {{(ACC_W + 1){1'b0}}, mu};
    assign prod     = a_ext * mu_ext;
    assign scaled   = ACC_W'(prod >>> MU_FRAC);
    assign sum_next = scaled + b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            side_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_next;
                side_out <= side_in;
            end
        end
    end

endmodule

// File: rtl/farrow_interp_pp.sv
// Piecewise-parabolic (alpha = 0.5) Farrow interpolator: 4-sample delay line,
// coefficient stage, two Horner MAC stages and a saturating Q1.15 output.
module farrow_interp_pp
    import timing_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic [MU_WIDTH-1:0]      mu,
    input  logic                     strobe,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid
);

    localparam int SIDE2_W = 1 + MU_WIDTH + ACC_W;

    logic signed [DATA_W-1:0] x_reg [4];
    logic signed [ACC_W-1:0]  x_ext [4];
    logic [MU_WIDTH-1:0]      mu_s_reg;
    logic                     stb_s_reg;
    logic                     cap_valid_reg;
    logic [2:0]               fill_reg;

    logic signed [ACC_W-1:0]  v2_reg, v1_reg, v0_reg;
    logic signed [ACC_W-1:0]  v2_next, v1_next;
    logic [MU_WIDTH-1:0]      mu1_reg;
    logic                     stb1_reg;
    logic                     valid1_reg;

    logic                     valid2;
    logic signed [ACC_W-1:0]  t2;
    logic [SIDE2_W-1:0]       side2;
    logic                     stb2;
    logic [MU_WIDTH-1:0]      mu2;
    logic signed [ACC_W-1:0]  v0_2;

    logic                     valid3;
    logic signed [ACC_W-1:0]  y_acc;
    logic                     stb3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign x_ext[gi] = {{(ACC_W - DATA_W){x_reg[gi][DATA_W-1]}}, x_reg[gi]};
        end

        for (gi = 1; gi < 4; gi++) begin : g_delay
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_reg[gi] <= '0;
                end else if (in_valid) begin
                    x_reg[gi] <= x_reg[gi-1];
                end
            end
        end
    endgenerate

    // The strobe only counts once the delay line holds 4 real samples, this one included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg[0]      <= '0;
            mu_s_reg      <= '0;
            stb_s_reg     <= 1'b0;
            cap_valid_reg <= 1'b0;
            fill_reg      <= '0;
        end else begin
            cap_valid_reg <= in_valid;
            if (in_valid) begin
                x_reg[0]  <= x_in;
                mu_s_reg  <= mu;
                stb_s_reg <= strobe && (fill_reg >= 3'd3);
                if (fill_reg != 3'd4) begin
                    fill_reg <= fill_reg + 3'd1;
                end
            end
        end
    end

    assign v2_next = (x_ext[0] - x_ext[1] - x_ext[2] + x_ext[3]) >>> 1;
    assign v1_next = ((x_ext[1] <<< 1) + x_ext[1] - x_ext[0] - x_ext[2] - x_ext[3]) >>> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg     <= '0;
            v1_reg     <= '0;
            v0_reg     <= '0;
            mu1_reg    <= '0;
            stb1_reg   <= 1'b0;
            valid1_reg <= 1'b0;
        end else begin
            valid1_reg <= cap_valid_reg;
            if (cap_valid_reg) begin
                v2_reg   <= v2_next;
                v1_reg   <= v1_next;
                v0_reg   <= x_ext[2];
                mu1_reg  <= mu_s_reg;
                stb1_reg <= stb_s_reg;
            end
        end
    end

    farrow_mac_stage #(
        .SIDE_W (SIDE2_W)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid1_reg),
        .a         (v2_reg),
        .mu        (mu1_reg),
        .b         (v1_reg),
        .side_in   ({stb1_reg, mu1_reg, v0_reg}),
        .out_valid (valid2),
        .sum       (t2),
        .side_out  (side2)
    );

    assign {stb2, mu2, v0_2} = side2;

    farrow_mac_stage #(
        .SIDE_W (1)
    ) u_stage3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid2),
        .a         (t2),
        .mu        (mu2),
        .b         (v0_2),
        .side_in   (stb2),
        .out_valid (valid3),
        .sum       (y_acc),
        .side_out  (stb3)
    );

    assign y_out   = sat(y_acc);
    assign y_valid = valid3 && stb3;

endmodule
